// File: rtl/regfile_pkg.sv
// Shared defaults, state encoding and constants for the multi-port register file.
// Imported by regfile_mp and regfile_scoreboard.
package regfile_pkg;

   localparam int unsigned RF_DATA_W = 32;
   localparam int unsigned RF_ADDR_W = 5;
   localparam int unsigned RF_NUM_RD = 2;
   localparam int unsigned RF_DEPTH  = 2 ** RF_ADDR_W;

   localparam logic [RF_DATA_W-1:0] ZERO_WORD = '0;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by load issue, cleared by writes.
// The clear port walks the array after reset; bit 0 is held at zero.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_W = RF_ADDR_W
) (
   input  logic                   clk,
   input  logic                   clr_en,
   input  logic [ADDR_W-1:0]      clr_idx,
   input  logic                   wr0,
   input  logic [ADDR_W-1:0]      waddr0,
   input  logic                   wr1,
   input  logic [ADDR_W-1:0]      waddr1,
   input  logic                   set,
   input  logic [ADDR_W-1:0]      set_addr,
   output logic [2**ADDR_W-1:0]   pending
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DEPTH-1:0] pending_nxt;

   // Clear sequence dominates; otherwise write-clears first so a same-address set wins.
   always_comb begin
      pending_nxt = pending;
      if (clr_en) begin
         pending_nxt[clr_idx] = 1'b0;
      end else begin
         if (wr0) pending_nxt[waddr0] = 1'b0;
         if (wr1) pending_nxt[waddr1] = 1'b0;
         if (set) pending_nxt[set_addr] = 1'b1;
      end
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      pending <= pending_nxt;
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file: two write ports (WB, load return), NUM_RD bypassed read ports,
// load-use scoreboard, and a post-reset sequence that zeroes every register.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = RF_DATA_W,
   parameter int unsigned ADDR_W = RF_ADDR_W,
   parameter int unsigned NUM_RD = RF_NUM_RD,
   parameter int unsigned BYPASS = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       init_done,
   input  logic                       we0,
   input  logic [ADDR_W-1:0]          waddr0,
   input  logic [DATA_W-1:0]          wdata0,
   input  logic                       we1,
   input  logic [ADDR_W-1:0]          waddr1,
   input  logic [DATA_W-1:0]          wdata1,
   input  logic [NUM_RD-1:0]          re,
   input  logic [NUM_RD*ADDR_W-1:0]   raddr,
   output logic [NUM_RD*DATA_W-1:0]   rdata,
   input  logic                       sb_set,
   input  logic [ADDR_W-1:0]          sb_addr,
   output logic [NUM_RD-1:0]          rd_pending
);

   localparam int unsigned       DEPTH    = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
   localparam logic              BYP      = (BYPASS != 0);
   localparam logic [DATA_W-1:0] ZERO_RD  = DATA_W'(ZERO_WORD);

   rf_state_e         state, state_nxt;
   logic [ADDR_W-1:0] clr_idx, clr_idx_nxt;
   logic              init_done_nxt;
   logic              clr_en;
   logic              run;

   logic              w0_ok, w1_ok, set_ok;
   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  sb_q;

   // State register; reset restarts the clear walk from index 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= CLEAR;
         clr_idx   <= '0;
         init_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         clr_idx   <= clr_idx_nxt;
         init_done <= init_done_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      clr_idx_nxt   = clr_idx;
      init_done_nxt = init_done;
      clr_en        = 1'b0;
      case (state)
         CLEAR: begin
            clr_en      = 1'b1;
            clr_idx_nxt = clr_idx + ADDR_W'(1);
            if (clr_idx == LAST_IDX) begin
               state_nxt     = RUN;
               init_done_nxt = 1'b1;
               clr_idx_nxt   = '0;
            end
         end
         RUN: begin
            state_nxt = RUN;
         end
         default: begin
            state_nxt     = CLEAR;
            clr_idx_nxt   = '0;
            init_done_nxt = 1'b0;
         end
      endcase
   end

   assign run    = (state == RUN);
   assign w0_ok  = run && we0 && (waddr0 != '0);
   assign w1_ok  = run && we1 && (waddr1 != '0);
   assign set_ok = run && sb_set;

   // Port 1 assigned last so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (clr_en) begin
         regs[clr_idx] <= ZERO_RD;
      end else begin
         if (w0_ok) regs[waddr0] <= wdata0;
         if (w1_ok) regs[waddr1] <= wdata1;
      end
   end

   regfile_scoreboard #(
      .ADDR_W (ADDR_W)
   ) u_sb (
      .clk      (clk),
      .clr_en   (clr_en),
      .clr_idx  (clr_idx),
      .wr0      (w0_ok),
      .waddr0   (waddr0),
      .wr1      (w1_ok),
      .waddr1   (waddr1),
      .set      (set_ok),
      .set_addr (sb_addr),
      .pending  (sb_q)
   );

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              hit0, hit1;
      logic [DATA_W-1:0] rd;

      assign ra   = raddr[i*ADDR_W +: ADDR_W];
      assign hit0 = BYP && we0 && (waddr0 == ra);
      assign hit1 = BYP && we1 && (waddr1 == ra);

      // Load-return port has bypass priority over WB, matching the write winner.
      always_comb begin
         rd = ZERO_RD;
         if (!run || !re[i] || (ra == '0)) begin
            rd = ZERO_RD;
         end else if (hit1) begin
            rd = wdata1;
         end else if (hit0) begin
            rd = wdata0;
         end else begin
            rd = regs[ra];
         end
      end

      assign rdata[i*DATA_W +: DATA_W] = rd;
      assign rd_pending[i] = run && re[i] && sb_q[ra] && !(hit0 || hit1);
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default instance (BYPASS=1) and a
// 64-bit / 16-entry / 3-read-port instance without bypass.
module tb_regfile_mp;

   localparam int ND     = 2;
   localparam int K_RD   = 0;
   localparam int K_PEND = 1;
   localparam int K_INIT = 2;

   typedef struct {
      string       tag;
      int          d;
      int          kind;
      int          p;
      logic [63:0] val;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst    [ND];
   logic        we0    [ND];
   logic        we1    [ND];
   logic        sb_set [ND];
   logic [4:0]  waddr0 [ND];
   logic [4:0]  waddr1 [ND];
   logic [4:0]  sb_addr[ND];
   logic [63:0] wdata0 [ND];
   logic [63:0] wdata1 [ND];
   logic [3:0]  re     [ND];
   logic [4:0]  ra     [ND][4];

   logic         init_a, init_b;
   logic [63:0]  rdata_a;
   logic [191:0] rdata_b;
   logic [1:0]   pend_a;
   logic [2:0]   pend_b;

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)) u_a (
      .clk(clk), .rst(rst[0]), .init_done(init_a),
      .we0(we0[0]), .waddr0(waddr0[0]), .wdata0(wdata0[0][31:0]),
      .we1(we1[0]), .waddr1(waddr1[0]), .wdata1(wdata1[0][31:0]),
      .re(re[0][1:0]), .raddr({ra[0][1], ra[0][0]}), .rdata(rdata_a),
      .sb_set(sb_set[0]), .sb_addr(sb_addr[0]), .rd_pending(pend_a)
   );

   regfile_mp #(.DATA_W(64), .ADDR_W(4), .NUM_RD(3), .BYPASS(0)) u_b (
      .clk(clk), .rst(rst[1]), .init_done(init_b),
      .we0(we0[1]), .waddr0(waddr0[1][3:0]), .wdata0(wdata0[1]),
      .we1(we1[1]), .waddr1(waddr1[1][3:0]), .wdata1(wdata1[1]),
      .re(re[1][2:0]), .raddr({ra[1][2][3:0], ra[1][1][3:0], ra[1][0][3:0]}),
      .rdata(rdata_b),
      .sb_set(sb_set[1]), .sb_addr(sb_addr[1][3:0]), .rd_pending(pend_b)
   );

   int vec_cnt = 0;
   int err_cnt = 0;
   exp_t exp_q[$];

   // reference model state
   logic [63:0] mregs[ND][32];
   logic        msb  [ND][32];
   logic        mrun [ND];
   int          mclr [ND];

   function automatic int nrd(input int d);   return (d == 0) ? 2 : 3;  endfunction
   function automatic int depth(input int d); return (d == 0) ? 32 : 16; endfunction
   function automatic logic byp(input int d); return (d == 0);           endfunction
   function automatic logic [4:0] amask(input int d);
      return (d == 0) ? 5'h1F : 5'h0F;
   endfunction
   function automatic logic [63:0] dmask(input int d);
      return (d == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] observe(input int d, input int kind, input int p);
      if (d == 0) begin
         if (kind == K_RD)   return {32'h0, rdata_a[p*32 +: 32]};
         if (kind == K_PEND) return 64'(pend_a[p]);
         return 64'(init_a);
      end
      if (kind == K_RD)   return rdata_b[p*64 +: 64];
      if (kind == K_PEND) return 64'(pend_b[p]);
      return 64'(init_b);
   endfunction

   task automatic ex(input string tag, input int d, input int kind, input int p, input logic [63:0] v);
      exp_t e;
      e.tag = tag; e.d = d; e.kind = kind; e.p = p; e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic push_model(input int d);
      logic [4:0]  a;
      logic [63:0] v;
      logic        h0, h1, pd;
      for (int p = 0; p < nrd(d); p++) begin
         a  = ra[d][p] & amask(d);
         h0 = we0[d] && ((waddr0[d] & amask(d)) == a);
         h1 = we1[d] && ((waddr1[d] & amask(d)) == a);
         if (!mrun[d] || !re[d][p] || a == 5'd0) v = 64'd0;
         else if (byp(d) && h1)                  v = wdata1[d] & dmask(d);
         else if (byp(d) && h0)                  v = wdata0[d] & dmask(d);
         else                                    v = mregs[d][a];
         pd = mrun[d] && re[d][p] && msb[d][a] && !(byp(d) && (h0 || h1));
         ex($sformatf("m%0d.rd%0d", d, p), d, K_RD, p, v);
         ex($sformatf("m%0d.pend%0d", d, p), d, K_PEND, p, 64'(pd));
      end
      ex($sformatf("m%0d.init", d), d, K_INIT, 0, 64'(mrun[d]));
   endtask

   task automatic model_edge(input int d);
      logic [4:0] a0, a1, sa;
      a0 = waddr0[d] & amask(d);
      a1 = waddr1[d] & amask(d);
      sa = sb_addr[d] & amask(d);
      if (rst[d]) begin
         mrun[d] = 1'b0;
         mclr[d] = 0;
      end else if (!mrun[d]) begin
         mregs[d][mclr[d]] = 64'd0;
         msb[d][mclr[d]]   = 1'b0;
         if (mclr[d] == depth(d) - 1) mrun[d] = 1'b1;
         else                         mclr[d]++;
      end else begin
         if (we0[d] && a0 != 5'd0) begin mregs[d][a0] = wdata0[d] & dmask(d); msb[d][a0] = 1'b0; end
         if (we1[d] && a1 != 5'd0) begin mregs[d][a1] = wdata1[d] & dmask(d); msb[d][a1] = 1'b0; end
         if (sb_set[d] && sa != 5'd0) msb[d][sa] = 1'b1;
      end
   endtask

   task automatic step();
      exp_t e;
      push_model(0);
      push_model(1);
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(e.tag, observe(e.d, e.kind, e.p), e.val);
      end
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
   endtask

   task automatic idle(input int d);
      we0[d] = 1'b0; we1[d] = 1'b0; sb_set[d] = 1'b0; re[d] = 4'h0;
      waddr0[d] = 5'd0; waddr1[d] = 5'd0; sb_addr[d] = 5'd0;
      wdata0[d] = 64'd0; wdata1[d] = 64'd0;
      for (int p = 0; p < 4; p++) ra[d][p] = 5'd0;
   endtask

   task automatic wr(input int d, input int port, input int a, input logic [63:0] v);
      if (port == 0) begin we0[d] = 1'b1; waddr0[d] = 5'(a); wdata0[d] = v; end
      else           begin we1[d] = 1'b1; waddr1[d] = 5'(a); wdata1[d] = v; end
   endtask

   task automatic rd(input int d, input int p, input int a);
      re[d][p] = 1'b1;
      ra[d][p] = 5'(a);
   endtask

   task automatic sbs(input int d, input int a);
      sb_set[d]  = 1'b1;
      sb_addr[d] = 5'(a);
   endtask

   initial begin
      for (int d = 0; d < ND; d++) begin
         idle(d);
         rst[d]  = 1'b1;
         mrun[d] = 1'b0;
         mclr[d] = 0;
         for (int r = 0; r < 32; r++) begin mregs[d][r] = 64'd0; msb[d][r] = 1'b0; end
      end
      @(posedge clk);
      model_edge(0); model_edge(1);
      #1;
      rd(0, 0, 3); rd(1, 0, 3);
      repeat (2) step();

      // clear sequence length, writes/sets ignored while clearing
      rst[0] = 1'b0; rst[1] = 1'b0;
      wr(0, 0, 3, 64'h55); wr(0, 1, 4, 64'h66); sbs(0, 4);
      wr(1, 0, 3, 64'h77); sbs(1, 3);
      rd(0, 1, 4); rd(1, 1, 3);
      for (int k = 0; k < 34; k++) begin
         ex("A.init_cnt", 0, K_INIT, 0, 64'(k >= 32));
         ex("B.init_cnt", 1, K_INIT, 0, 64'(k >= 16));
         step();
         if (k == 0) begin
            we0[0] = 1'b0; we1[0] = 1'b0; sb_set[0] = 1'b0;
            we0[1] = 1'b0; sb_set[1] = 1'b0;
         end
      end
      ex("A.clr_wr3", 0, K_RD, 0, 64'd0);
      ex("A.clr_wr4", 0, K_RD, 1, 64'd0);
      ex("A.clr_sb4", 0, K_PEND, 1, 64'd0);
      ex("B.clr_sb3", 1, K_PEND, 1, 64'd0);
      step();

      for (int r = 0; r < 32; r++) begin
         idle(0);
         rd(0, 0, r); rd(0, 1, 31 - r);
         ex("A.zero_p0", 0, K_RD, 0, 64'd0);
         ex("A.zero_p1", 0, K_RD, 1, 64'd0);
         step();
      end

      // dual write to r5, port 1 wins; r0 write dropped
      idle(0);
      wr(0, 0, 5, 64'h1111_1111); wr(0, 1, 5, 64'h2222_2222); rd(0, 1, 5);
      ex("A.dual_byp", 0, K_RD, 1, 64'h2222_2222);
      step();
      idle(0);
      rd(0, 0, 5); wr(0, 0, 0, 64'hFFFF_FFFF);
      ex("A.dual_wr", 0, K_RD, 0, 64'h2222_2222);
      step();
      idle(0);
      rd(0, 0, 0);
      ex("A.r0_zero", 0, K_RD, 0, 64'd0);
      step();

      // same-cycle bypass (A) vs array-only reads (B)
      idle(0); idle(1);
      wr(0, 0, 7, 64'hDEAD_BEEF); rd(0, 1, 7); ra[0][0] = 5'd7;
      ex("A.byp_r7", 0, K_RD, 1, 64'hDEAD_BEEF);
      ex("A.re_off", 0, K_RD, 0, 64'd0);
      wr(1, 0, 7, 64'hDEAD_BEEF); rd(1, 1, 7);
      ex("B.nobyp_old", 1, K_RD, 1, 64'd0);
      step();
      idle(0); idle(1);
      wr(1, 1, 3, 64'h0123_4567_89AB_CDEF);
      rd(1, 1, 7); rd(1, 0, 3); rd(1, 2, 0);
      ex("B.r7_next", 1, K_RD, 1, 64'hDEAD_BEEF);
      ex("B.r3_old", 1, K_RD, 0, 64'd0);
      ex("B.r0_p2", 1, K_RD, 2, 64'd0);
      step();
      idle(1);
      rd(1, 2, 3); rd(1, 0, 7); ra[1][1] = 5'd7;
      ex("B.r3_p2", 1, K_RD, 2, 64'h0123_4567_89AB_CDEF);
      ex("B.r7_p0", 1, K_RD, 0, 64'hDEAD_BEEF);
      ex("B.re_off", 1, K_RD, 1, 64'd0);
      step();

      // scoreboard: set, bypassed clear, set-beats-clear
      idle(0); idle(1);
      sbs(0, 9); rd(0, 0, 9); sbs(1, 9);
      ex("A.sb_pre", 0, K_PEND, 0, 64'd0);
      step();
      idle(0); idle(1);
      rd(0, 0, 9); rd(1, 0, 9);
      ex("A.sb_set", 0, K_PEND, 0, 64'd1);
      ex("B.sb_set", 1, K_PEND, 0, 64'd1);
      step();
      idle(0); idle(1);
      wr(0, 1, 9, 64'hABCD); rd(0, 0, 9); wr(1, 1, 9, 64'h5A5A); rd(1, 0, 9);
      ex("A.sb_byp", 0, K_PEND, 0, 64'd0);
      ex("A.sb_byp_d", 0, K_RD, 0, 64'hABCD);
      ex("B.sb_nobyp", 1, K_PEND, 0, 64'd1);
      step();
      idle(0); idle(1);
      rd(0, 0, 9); rd(1, 0, 9);
      ex("A.sb_clr", 0, K_PEND, 0, 64'd0);
      ex("B.sb_clr", 1, K_PEND, 0, 64'd0);
      step();
      idle(0);
      sbs(0, 9); wr(0, 0, 9, 64'h1234); rd(0, 1, 9);
      step();
      idle(0);
      rd(0, 1, 9);
      ex("A.sb_win", 0, K_PEND, 1, 64'd1);
      ex("A.sb_win_d", 0, K_RD, 1, 64'h1234);
      step();

      // random traffic on both instances
      for (int n = 0; n < 400; n++) begin
         for (int d = 0; d < ND; d++) begin
            we0[d]     = 1'($urandom);
            we1[d]     = 1'($urandom);
            sb_set[d]  = ($urandom_range(0, 3) == 0);
            waddr0[d]  = 5'($urandom_range(0, 7));
            waddr1[d]  = 5'($urandom_range(0, 7));
            sb_addr[d] = 5'($urandom_range(0, 7));
            wdata0[d]  = {$urandom, $urandom};
            wdata1[d]  = {$urandom, $urandom};
            re[d]      = 4'($urandom);
            for (int p = 0; p < 4; p++)
               ra[d][p] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, depth(d) - 1))
                                                      : 5'($urandom_range(0, 7));
         end
         step();
      end

      // reset mid-clear at index 17 restarts the walk
      idle(0); idle(1);
      rst[0] = 1'b1;
      step();
      rst[0] = 1'b0;
      repeat (17) step();
      rst[0] = 1'b1;
      step();
      rst[0] = 1'b0;
      for (int k = 0; k < 34; k++) begin
         ex("A.reinit_cnt", 0, K_INIT, 0, 64'(k >= 32));
         step();
      end
      idle(0);
      rd(0, 0, 5); rd(0, 1, 9);
      ex("A.reinit_r5", 0, K_RD, 0, 64'd0);
      ex("A.reinit_sb9", 0, K_PEND, 1, 64'd0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the OpenMIPS core, successor to the fixed 32×32, 2-read/1-write file. It adds a second write port (MEM/WB plus a late-load return path), a configurable number of read ports with write-to-read bypass, and a pending-write scoreboard for load-use hazard detection. After reset it also runs a clearing sequence, so every architectural register starts at zero. It sits between ID (reads) and WB (writes), and feeds the hazard unit.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return array contents only

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- init_done  out  1  high once the clear sequence is complete
- we0  in  1  write enable, port 0 (WB)
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (load return)
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- re  in  NUM_RD  per-port read enable
- raddr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  read data, packed the same way
- sb_set  in  1  mark sb_addr as pending (a load has been issued)
- sb_addr  in  ADDR_W  scoreboard set address
- rd_pending  out  NUM_RD  read port i targets a pending register that is not bypassed this cycle

## Operation
- FSM states:
  - CLEAR: entered on rst. clr_idx starts at 0 and increments by 1 each cycle; each cycle writes zero to regs[clr_idx] and clears sb[clr_idx]. Transitions to RUN the cycle after clr_idx = 2**ADDR_W-1.
  - RUN: normal operation; holds until the next rst.
- During CLEAR:
  - we0/we1/sb_set are ignored.
  - rdata = 0 and rd_pending = 0.
  - init_done = 0.
- Writes (RUN only):
  - A port writes when we=1 and waddr≠0.
  - If both ports target the same address, port 1 wins.
  - Register 0 is never written and always reads 0.
- Reads (combinational), evaluated per port i in this priority order:
  - re[i]=0 or raddr=0 → 0.
  - BYPASS=1 and we1 && waddr1==raddr → wdata1.
  - BYPASS=1 and we0 && waddr0==raddr → wdata0.
  - otherwise → regs[raddr].
- Scoreboard, one bit per register; bit 0 is constant 0:
  - A valid write to an address clears its bit.
  - sb_set sets sb[sb_addr].
  - Set and clear on the same address in the same cycle: set wins.
  - rd_pending[i] = re[i] && sb[raddr] && !(BYPASS && a write hits raddr this cycle).

## Timing
- Reset: the first clk edge with rst=1 enters CLEAR. init_done rises after exactly 2**ADDR_W cycles following rst deassertion (32 for default parameters).
- rst asserted mid-CLEAR restarts the sequence from index 0.
- Read latency is 0 cycles (combinational). Write latency is 1 cycle.
- With BYPASS=0, a write is visible on a read one cycle after the write edge.
- Scoreboard updates take effect at the clock edge. rd_pending is combinational from the registered sb and the current write ports.
- Outputs during and immediately after reset: init_done=0, rdata=0, rd_pending=0.

## Structure
- Package regfile_pkg holds:
  - defaults for DATA_W/ADDR_W/NUM_RD
  - the state enum {CLEAR, RUN}
  - helper localparams RF_DEPTH and ZERO_WORD
- One natural sub-module: regfile_scoreboard, which contains the sb bit vector, the set/clear priority logic and the clear-port input.
- Read muxes are built with a generate loop over NUM_RD.

## Test plan
- Reset → init_done: assert rst for 3 cycles, release → init_done=0 for 32 cycles, then 1. All 32 registers read 0. A write attempted during CLEAR has no effect.
- Dual write, same address: we0/we1 both to r5 with wdata0=0x1111_1111, wdata1=0x2222_2222 → the next cycle, r5 reads 0x2222_2222. A write of 0xFFFF_FFFF to r0 → r0 reads 0.
- Bypass: write r7=0xDEAD_BEEF while reading r7 on port 1 in the same cycle → rdata port 1 = 0xDEAD_BEEF (BYPASS=1). With BYPASS=0, the same-cycle read gives the old value and the next cycle gives 0xDEAD_BEEF. re=0 → 0.
- Scoreboard: sb_set r9, then read r9 → rd_pending=1. When we1 writes r9, rd_pending=0 in that cycle (bypass) and stays 0 afterwards. sb_set r9 together with a write to r9 → pending stays 1.
- Mid-sequence reset: assert rst when clr_idx=17 → the clear sequence restarts, and init_done rises exactly 32 cycles after release.
- Parameter sweep: ADDR_W=4, NUM_RD=3, DATA_W=64 → CLEAR lasts 16 cycles. All 3 read ports independently return the correct 64-bit values and each applies its own zero/bypass rules.
